dma_chn_ctrl: RTL
=================

# dma_chn_ctrl

Channel command and status controller for one DMA channel. It sits directly downstream of the APB register block and consumes the CH_CMD, CH_STATUS and CH_INTREN writes and the CH_XSIZE value. It runs the channel state machine, issues beat requests to the transfer engine and counts down the remaining size. It returns live CMD/STATUS read-back values and a level interrupt.

## Interface
- `WIDTH`, 32, register width; must be ≥ 22.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_wr_en` in 1: single-cycle pulse for a CH_CMD write.
- `cmd_wdata` in WIDTH: value written to CH_CMD.
- `stat_wr_en` in 1: single-cycle pulse for a CH_STATUS write.
- `stat_wdata` in WIDTH: CH_STATUS write data (write-1-to-clear).
- `cfg_CH_INTREN` in WIDTH: interrupt enables; bits [3:0] = DONE, ERR, DISABLED, STOPPED.
- `cfg_CH_XSIZE` in WIDTH: bits [15:0] = beat count; sampled on ENABLECMD.
- `beat_ack` in 1: engine has completed one beat.
- `beat_err` in 1: engine error, qualified by `beat_ack`.
- `beat_req` out 1: channel requests a beat.
- `ch_cmd_rd` out WIDTH: CH_CMD read-back; bit0 = 1 while the channel is not IDLE, bit4 = 1 while PAUSED, all other bits 0.
- `ch_status` out WIDTH: [3:0] INTR = [19:16] & INTREN[3:0]; [16] DONE, [17] ERR, [18] DISABLED, [19] STOPPED, [20] PAUSED; other bits 0.
- `xsize_rem` out 16: remaining beats.
- `irq` out 1: OR of `ch_status[3:0]`.

## Operation
- CH_CMD bits:
  - bit0 ENABLE, bit1 CLEAR, bit2 DISABLE, bit3 STOP, bit4 PAUSE, bit5 RESUME.
  - When several bits are set in one write, precedence is DISABLE > STOP > PAUSE > RESUME > ENABLE.
  - CLEAR is evaluated independently.
- States: IDLE, RUN, STOPPING, PAUSING, PAUSED (encoded binary).
- IDLE:
  - ENABLE with XSIZE[15:0] ≠ 0: load `xsize_rem`, clear STAT [19:16], go to RUN.
  - ENABLE with XSIZE[15:0] = 0: set DONE and stay in IDLE.
  - CLEAR: zero STAT [20:16] and `xsize_rem`.
  - All other commands are ignored.
- RUN:
  - `beat_req` = 1 continuously.
  - Each `beat_ack` decrements `xsize_rem`.
  - Ack with `xsize_rem` = 1: go to IDLE and set DONE.
  - Ack with `beat_err`: go to IDLE and set ERR; do not decrement.
  - STOP: go to STOPPING.
  - PAUSE: go to PAUSING.
  - ENABLE, RESUME and CLEAR are ignored.
- STOPPING and PAUSING:
  - `beat_req` stays 1 until the next ack; that ack is counted.
  - Then STOPPING goes to IDLE and sets STOPPED; PAUSING goes to PAUSED.
  - If that ack completes the transfer (`xsize_rem` 1→0), go to IDLE and set DONE instead. DONE wins.
- PAUSED:
  - `beat_req` = 0, STAT PAUSED = 1.
  - RESUME: go to RUN.
  - STOP: go to IDLE and set STOPPED.
- DISABLE in any non-IDLE state:
  - Next state is IDLE and DISABLED is set.
  - `beat_req` drops the next cycle even with a beat outstanding.
  - An ack arriving in the same cycle is ignored.
- Status write: bits [19:16] of `stat_wdata` clear the matching STAT bits (W1C).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- `beat_ack` while `beat_req` = 0 is ignored.

## Timing
- Reset values: state IDLE; `beat_req` = 0, `xsize_rem` = 0, `ch_status` = 0, `ch_cmd_rd` = 0, `irq` = 0.
- `reset` asserted mid-transfer: outputs return to their reset values immediately (asynchronous); no status is retained.
- ENABLE written in cycle N: `beat_req` = 1 and `ch_cmd_rd[0]` = 1 in cycle N+1.
- Final ack in cycle M: `beat_req` = 0, DONE = 1 and `irq` = 1 (if enabled) in M+1.
- All outputs are registered except INTR bits and `irq`, which are combinational from the registered STAT bits and `cfg_CH_INTREN`.
- Back-to-back acks, one per cycle, are sustained with no bubbles.

## Configuration
- `DMA_CHN_PAUSE_EN` defined:
  - PAUSE/RESUME behave as described above.
  - PAUSING and PAUSED states exist.
- `DMA_CHN_PAUSE_EN` undefined:
  - PAUSE and RESUME bits are ignored in every state.
  - PAUSING and PAUSED states are not generated.
  - `ch_status[20]` and `ch_cmd_rd[4]` are tied to 0.

## Test plan
- XSIZE = 3, INTREN = 0x1, ENABLE; ack on 3 consecutive cycles → `xsize_rem` 3→2→1→0, `beat_req` low and `ch_status` = 0x0001_0001, `irq` = 1 the cycle after the third ack. Then write STATUS 0x0001_0000 → `ch_status` = 0, `irq` = 0.
- XSIZE = 5, 2 acks, then STOP; next ack → `xsize_rem` = 2, IDLE, STOPPED = 1. Repeat with XSIZE = 3 so the post-STOP ack is the final beat → DONE = 1, STOPPED = 0.
- XSIZE = 4, PAUSE, ack → PAUSED, `ch_status[20]` = 1, `beat_req` = 0, `xsize_rem` = 3. RESUME → RUN and `beat_req` = 1 next cycle. Rebuilt without the macro: PAUSE has no effect.
- XSIZE = 8, DISABLE written in the same cycle as an ack → `xsize_rem` stays 8 (that ack is ignored), DISABLED = 1, `beat_req` = 0 the next cycle. Write CMD = 0x7 (ENABLE + DISABLE + CLEAR) while running → DISABLE taken.
- Ack with `beat_err` and INTREN = 0x2 → IDLE, `ch_status` = 0x0002_0002, `xsize_rem` unchanged. ENABLE with XSIZE = 0 → DONE set, `beat_req` never asserts.
- Assert `reset` mid-RUN with `xsize_rem` = 6 → all outputs 0 immediately, without waiting for a clock edge; ENABLE after release restarts cleanly.

Source files
------------

// File: rtl/dma_chn_ctrl.sv
// DMA channel command/status controller: channel FSM, beat requests, size countdown, W1C status, level irq.
// Optional PAUSE/RESUME support (PAUSING/PAUSED states) is built when DMA_CHN_PAUSE_EN is defined.
module dma_chn_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_wr_en,
  input  logic [WIDTH-1:0] cmd_wdata,
  input  logic             stat_wr_en,
  input  logic [WIDTH-1:0] stat_wdata,
  input  logic [WIDTH-1:0] cfg_CH_INTREN,
  input  logic [WIDTH-1:0] cfg_CH_XSIZE,
  input  logic             beat_ack,
  input  logic             beat_err,
  output logic             beat_req,
  output logic [WIDTH-1:0] ch_cmd_rd,
  output logic [WIDTH-1:0] ch_status,
  output logic [15:0]      xsize_rem,
  output logic             irq
);

`ifdef DMA_CHN_PAUSE_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STOPPING, S_PAUSING, S_PAUSED} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;
`endif

  state_t      r_state, w_nxt;
  logic [15:0] r_xsize_rem, w_rem_nxt;
  logic [3:0]  r_stat;            // {STOPPED, DISABLED, ERR, DONE}
  logic [3:0]  w_set, w_clr, w_w1c, w_intr;
  logic        r_beat_req, r_busy, r_paused;
  logic        w_ack, w_dis, w_stop, w_en, w_clear;
  logic        w_unused;

  assign w_dis   = cmd_wr_en & cmd_wdata[2];
  assign w_stop  = cmd_wr_en & cmd_wdata[3] & ~cmd_wdata[2];
  assign w_clear = cmd_wr_en & cmd_wdata[1];

`ifdef DMA_CHN_PAUSE_EN
  logic w_pause, w_resume;
  assign w_pause  = cmd_wr_en & cmd_wdata[4] & ~|cmd_wdata[3:2];
  assign w_resume = cmd_wr_en & cmd_wdata[5] & ~|cmd_wdata[4:2];
  assign w_en     = cmd_wr_en & cmd_wdata[0] & ~|cmd_wdata[5:2];
  assign w_unused = ^{cmd_wdata[WIDTH-1:6], stat_wdata[WIDTH-1:20], stat_wdata[15:0],
                      cfg_CH_INTREN[WIDTH-1:4], cfg_CH_XSIZE[WIDTH-1:16]};
`else
  assign w_en     = cmd_wr_en & cmd_wdata[0] & ~|cmd_wdata[3:2];
  assign w_unused = ^{cmd_wdata[WIDTH-1:4], stat_wdata[WIDTH-1:20], stat_wdata[15:0],
                      cfg_CH_INTREN[WIDTH-1:4], cfg_CH_XSIZE[WIDTH-1:16]};
`endif

  // Acks are only meaningful while a beat is actually requested
  assign w_ack = beat_ack & r_beat_req;
  assign w_w1c = stat_wr_en ? stat_wdata[19:16] : 4'h0;

  always_comb begin
    w_nxt     = r_state;
    w_rem_nxt = r_xsize_rem;
    w_set     = 4'h0;
    w_clr     = 4'h0;
    if (r_state != S_IDLE && w_dis) begin
      w_nxt    = S_IDLE;
      w_set[2] = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_clear) begin
            w_clr     = 4'hF;
            w_rem_nxt = '0;
          end
          if (w_en) begin
            if (cfg_CH_XSIZE[15:0] != 16'd0) begin
              w_rem_nxt = cfg_CH_XSIZE[15:0];
              w_clr     = 4'hF;
              w_nxt     = S_RUN;
            end else begin
              w_set[0] = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_ack && beat_err) begin
            w_nxt    = S_IDLE;
            w_set[1] = 1'b1;
          end else if (w_ack && r_xsize_rem == 16'd1) begin
            w_rem_nxt = '0;
            w_nxt     = S_IDLE;
            w_set[0]  = 1'b1;
          end else begin
            if (w_ack) w_rem_nxt = r_xsize_rem - 16'd1;
            if (w_stop) w_nxt = S_STOPPING;
`ifdef DMA_CHN_PAUSE_EN
            else if (w_pause) w_nxt = S_PAUSING;
`endif
          end
        end
        S_STOPPING: begin
          if (w_ack) begin
            w_nxt = S_IDLE;
            if (beat_err) w_set[1] = 1'b1;
            else begin
              w_rem_nxt = r_xsize_rem - 16'd1;
              if (r_xsize_rem == 16'd1) w_set[0] = 1'b1;
              else                      w_set[3] = 1'b1;
            end
          end
        end
`ifdef DMA_CHN_PAUSE_EN
        S_PAUSING: begin
          if (w_ack) begin
            if (beat_err) begin
              w_nxt    = S_IDLE;
              w_set[1] = 1'b1;
            end else begin
              w_rem_nxt = r_xsize_rem - 16'd1;
              if (r_xsize_rem == 16'd1) begin
                w_nxt    = S_IDLE;
                w_set[0] = 1'b1;
              end else begin
                w_nxt = S_PAUSED;
              end
            end
          end else if (w_stop) begin
            w_nxt = S_STOPPING;
          end
        end
        S_PAUSED: begin
          if (w_stop) begin
            w_nxt    = S_IDLE;
            w_set[3] = 1'b1;
          end else if (w_resume) begin
            w_nxt = S_RUN;
          end
        end
`endif
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_xsize_rem <= '0;
      r_stat      <= '0;
      r_beat_req  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_xsize_rem <= w_rem_nxt;
      // a set in the same cycle beats a W1C clear
      r_stat      <= (r_stat & ~w_clr & ~w_w1c) | w_set;
`ifdef DMA_CHN_PAUSE_EN
      r_beat_req  <= (w_nxt == S_RUN) || (w_nxt == S_STOPPING) || (w_nxt == S_PAUSING);
`else
      r_beat_req  <= (w_nxt == S_RUN) || (w_nxt == S_STOPPING);
`endif
      r_busy      <= (w_nxt != S_IDLE);
    end
  end

`ifdef DMA_CHN_PAUSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_paused <= 1'b0;
    else       r_paused <= (w_nxt == S_PAUSED);
  end
`else
  assign r_paused = 1'b0;
`endif

  assign w_intr    = r_stat & cfg_CH_INTREN[3:0];
  assign irq       = |w_intr;
  assign beat_req  = r_beat_req;
  assign xsize_rem = r_xsize_rem;

  always_comb begin
    ch_cmd_rd     = '0;
    ch_cmd_rd[0]  = r_busy;
    ch_cmd_rd[4]  = r_paused;
    ch_status        = '0;
    ch_status[3:0]   = w_intr;
    ch_status[19:16] = r_stat;
    ch_status[20]    = r_paused;
  end

endmodule
